gps_sample_capture: RTL and testbench
=====================================

Name: gps_sample_capture

Overview:
- Front-end capture stage directly upstream of the SPI bridge state machine.
- Synchronises the GPS front-end sample clock (GPS_CLK) and the I0/I1/Q0/Q1 sign/magnitude bits into the MCU_CLK_25_000 domain.
- Captures one 4-bit sample per GPS_CLK rising edge and buffers samples in a small FIFO.
- Presents samples to the bridge as SAMPLE_OUT plus a level DATAREADY, with a DATA_ACK pop handshake and overflow accounting.

Parameters:
- FIFO_DEPTH, 8: sample FIFO entries; must be a power of 2, and at least 2.
- SYNC_STAGES, 2: flip-flop depth of the GPS_CLK and GPS data synchronisers; at least 2.
- OVF_CNT_W, 8: width of the dropped-sample counter.

Ports:
- MCU_CLK_25_000  in  1  sole clock, 25 MHz, all logic on its rising edge.
- RESET  in  1  synchronous reset, active-high.
- CAPTURE_EN  in  1  level; enables sample capture.
- GPS_CLK  in  1  front-end sample clock, treated as asynchronous data.
- GPS_I0, GPS_I1, GPS_Q0, GPS_Q1  in  1 each  front-end sample bits, asynchronous.
- SAMPLE_OUT  out  4  FIFO head {I0,I1,Q0,Q1}, bit 3 = I0.
- DATAREADY  out  1  FIFO non-empty.
- DATA_ACK  in  1  one-cycle pop strobe from the bridge.
- FIFO_LEVEL  out  log2(FIFO_DEPTH)+1  current occupancy.
- OVERFLOW  out  1  sticky: at least one sample was dropped.
- OVF_COUNT  out  OVF_CNT_W  dropped samples, saturating.

Behaviour:
- Reset (RESET high at a clock edge) takes effect on that edge:
  - SAMPLE_OUT=0, DATAREADY=0, FIFO_LEVEL=0, OVERFLOW=0, OVF_COUNT=0.
  - FIFO pointers are cleared.
  - GPS_CLK synchroniser and edge-history flops are set to 1; data synchroniser flops are cleared to 0.
  - FSM goes to DISARMED.
  - Reset mid-operation discards all buffered samples with no partial state kept.
- Synchroniser:
  - GPS_CLK and the four data bits pass through identical SYNC_STAGES-deep chains, so they stay aligned.
  - A rising edge is detected when the GPS_CLK chain output is 1 and the edge-history flop is 0.
  - Because the flops reset to 1, GPS_CLK held high through reset gives no spurious edge.
- Capture timing:
  - Let edge k be the first MCU clock edge that samples GPS_CLK high.
  - The captured nibble is the data sampled at edge k.
  - It is written to the FIFO on edge k+SYNC_STAGES.
  - DATAREADY and SAMPLE_OUT are valid after that same edge (first-word-fall-through).
- Rate limit: GPS_CLK high and low phases must each be at least 2 MCU clocks. The sustained rate must stay at or below the bridge drain rate (about 1 sample per 6 clocks); the FIFO absorbs bursts only.
- FSM states:
  - DISARMED: edges ignored. Goes to ARMING when CAPTURE_EN=1.
  - ARMING: waits SYNC_STAGES+1 clocks so the synchroniser is flushed, then goes to RUN. Goes to DISARMED if CAPTURE_EN drops.
  - RUN: each detected edge pushes one sample. Goes to DISARMED when CAPTURE_EN=0; an edge in that same cycle is still captured.
  - Encoding is illegal-state safe: undefined codes go to DISARMED on the next clock.
- Disarming does not flush the FIFO; buffered samples remain poppable.
- Pop: DATA_ACK=1 while DATAREADY=1 removes the head on that edge; the next entry appears after the edge. DATA_ACK while empty is ignored.
- Push and pop in the same cycle:
  - Non-empty FIFO: both occur and FIFO_LEVEL is unchanged.
  - Empty FIFO: the push occurs and the ack is ignored.
- Full FIFO:
  - Full with a push and a pop in the same cycle: both occur, no overflow.
  - Full with a push and no pop: the new sample is dropped and the FIFO is unchanged. OVERFLOW is set and OVF_COUNT increments, holding at 2^OVF_CNT_W-1.
  - OVERFLOW and OVF_COUNT clear only on RESET.
- Pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH. FIFO_LEVEL ranges 0..FIFO_DEPTH.

Decomposition:
- Shared package gps_capture_pkg holds:
  - SAMPLE_W=4 and the bit indices I0_BIT=3, I1_BIT=2, Q0_BIT=1, Q1_BIT=0.
  - The FSM state constants DISARMED, ARMING, RUN.
  - The default FIFO_DEPTH.
- One sub-module, sample_fifo: parameterised first-word-fall-through FIFO with push, pop, full, empty and level outputs.
- Synchroniser, edge detection, FSM and overflow logic live in the top level.

Test Plan:
- Reset with GPS_CLK held high, CAPTURE_EN=1 for 20 clocks, no GPS_CLK toggles -> DATAREADY stays 0, FIFO_LEVEL=0.
- Single edge with GPS data {1,0,1,1} in RUN -> DATAREADY rises exactly 2 clocks after the edge is first sampled, SAMPLE_OUT=4'b1011. One DATA_ACK then gives DATAREADY=0.
- 8 edges with no acks, then a 9th edge -> FIFO_LEVEL=8, OVERFLOW=1, OVF_COUNT=1; popping returns samples 1..8 in order.
- FIFO full and an edge coinciding with DATA_ACK -> FIFO_LEVEL stays 8, OVERFLOW stays 0, newest sample at the tail.
- 300 edges with no acks -> OVF_COUNT saturates at 255.
- RESET asserted with FIFO_LEVEL=5 -> next cycle DATAREADY=0 and FIFO_LEVEL=0. Dropping CAPTURE_EN with 3 samples buffered -> all 3 samples still poppable, and later edges are not captured.

Source files
------------

// File: rtl/gps_capture_pkg.sv
// Shared definitions for the GPS sample capture front end.
// Holds the sample layout (width and bit positions of I0/I1/Q0/Q1),
// the capture FSM state type and the default sample FIFO depth.
package gps_capture_pkg;

  localparam int SAMPLE_W = 4;

  // Bit positions inside a captured nibble {I0,I1,Q0,Q1}
  localparam int I0_BIT = 3;
  localparam int I1_BIT = 2;
  localparam int Q0_BIT = 1;
  localparam int Q1_BIT = 0;

  localparam int DEFAULT_FIFO_DEPTH = 8;

  // Code 2'b11 is unused; the FSM sends it back to DISARMED
  typedef enum logic [1:0] {
    DISARMED = 2'b00,
    ARMING   = 2'b01,
    RUN      = 2'b10
  } cap_state_t;

endpackage

// File: rtl/gps_sample_capture_fifo.sv
// First-word-fall-through sample FIFO.
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   push, wr_data - write request and data; ignored when full unless a pop
//                   happens on the same edge
//   pop           - remove the head; ignored when empty
//   rd_data       - current head (zero while empty)
//   full, empty   - occupancy flags
//   level         - occupancy, 0..DEPTH
// DEPTH must be a power of two (>= 2) so the pointers wrap for free.
module sample_fifo
  import gps_capture_pkg::*;
#(
  parameter int DEPTH = DEFAULT_FIFO_DEPTH,
  parameter int W     = SAMPLE_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             wr_data,
  input  logic                     pop,
  output logic [W-1:0]             rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));

  // A pop on a full FIFO frees the slot the simultaneous push needs
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; stale entries are never visible because
  // the head is masked while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = empty ? '0 : mem[rd_ptr];
  assign level   = count;

endmodule

// File: rtl/gps_sample_capture.sv
// GPS front-end sample capture.
// Brings GPS_CLK and the I0/I1/Q0/Q1 bits into the MCU_CLK_25_000 domain
// through equal-depth synchronisers, captures one nibble per GPS_CLK rising
// edge while armed, and buffers the nibbles for the SPI bridge.
// Ports:
//   MCU_CLK_25_000 - sole clock
//   RESET          - synchronous active-high reset
//   CAPTURE_EN     - level, arms/disarms capture
//   GPS_CLK, GPS_I0, GPS_I1, GPS_Q0, GPS_Q1 - asynchronous front-end inputs
//   SAMPLE_OUT     - FIFO head {I0,I1,Q0,Q1}
//   DATAREADY      - FIFO non-empty
//   DATA_ACK       - pop strobe
//   FIFO_LEVEL     - occupancy
//   OVERFLOW       - sticky drop flag
//   OVF_COUNT      - saturating drop count
// Handshake: SAMPLE_OUT is valid whenever DATAREADY=1; a DATA_ACK sampled
// high on a clock edge while DATAREADY=1 consumes the head on that edge and
// the next entry (if any) is presented after it. DATA_ACK while DATAREADY=0
// has no effect. There is no back-pressure towards the front end: a sample
// arriving at a full FIFO with no simultaneous pop is dropped and counted.
module gps_sample_capture
  import gps_capture_pkg::*;
#(
  parameter int FIFO_DEPTH  = DEFAULT_FIFO_DEPTH,
  parameter int SYNC_STAGES = 2,
  parameter int OVF_CNT_W   = 8
) (
  input  logic                          MCU_CLK_25_000,
  input  logic                          RESET,
  input  logic                          CAPTURE_EN,
  input  logic                          GPS_CLK,
  input  logic                          GPS_I0,
  input  logic                          GPS_I1,
  input  logic                          GPS_Q0,
  input  logic                          GPS_Q1,
  output logic [SAMPLE_W-1:0]           SAMPLE_OUT,
  output logic                          DATAREADY,
  input  logic                          DATA_ACK,
  output logic [$clog2(FIFO_DEPTH):0]   FIFO_LEVEL,
  output logic                          OVERFLOW,
  output logic [OVF_CNT_W-1:0]          OVF_COUNT
);

  // ARMING lasts SYNC_STAGES+1 clocks: counter runs 0..SYNC_STAGES
  localparam int ACW = $clog2(SYNC_STAGES + 2);
  localparam logic [ACW-1:0] ARM_LAST = ACW'(SYNC_STAGES);

  logic [SAMPLE_W-1:0]                    gps_raw;
  logic [SYNC_STAGES-1:0]                 clk_sync;
  logic [SYNC_STAGES-1:0][SAMPLE_W-1:0]   data_sync;
  logic                                   clk_hist;
  logic                                   gps_edge;

  cap_state_t     state_q;
  cap_state_t     state_d;
  logic [ACW-1:0] arm_cnt;

  logic push;
  logic fifo_full;
  logic fifo_empty;
  logic drop;

  always_comb begin
    gps_raw         = '0;
    gps_raw[I0_BIT] = GPS_I0;
    gps_raw[I1_BIT] = GPS_I1;
    gps_raw[Q0_BIT] = GPS_Q0;
    gps_raw[Q1_BIT] = GPS_Q1;
  end

  // Clock and data chains have the same depth, so the data word leaving
  // the chain alongside the first high GPS_CLK is the one sampled on the
  // same MCU edge. Clock flops reset high so a GPS_CLK held high through
  // reset does not look like a fresh rising edge.
  always_ff @(posedge MCU_CLK_25_000) begin
    if (RESET) begin
      clk_sync  <= '1;
      clk_hist  <= 1'b1;
      data_sync <= '0;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], GPS_CLK};
      data_sync <= {data_sync[SYNC_STAGES-2:0], gps_raw};
      clk_hist  <= clk_sync[SYNC_STAGES-1];
    end
  end

  assign gps_edge = clk_sync[SYNC_STAGES-1] & ~clk_hist;

  // Capture FSM
  always_ff @(posedge MCU_CLK_25_000) begin
    if (RESET) begin
      state_q <= DISARMED;
      arm_cnt <= '0;
    end else begin
      state_q <= state_d;
      arm_cnt <= (state_q == ARMING) ? arm_cnt + ACW'(1) : '0;
    end
  end

  always_comb begin
    state_d = DISARMED;
    case (state_q)
      DISARMED: state_d = CAPTURE_EN ? ARMING : DISARMED;
      ARMING: begin
        if (!CAPTURE_EN)            state_d = DISARMED;
        else if (arm_cnt == ARM_LAST) state_d = RUN;
        else                        state_d = ARMING;
      end
      RUN:      state_d = CAPTURE_EN ? RUN : DISARMED;
      default:  state_d = DISARMED;
    endcase
  end

  // Push decision uses the current state, so an edge in the same cycle
  // that CAPTURE_EN falls is still taken.
  assign push = gps_edge & (state_q == RUN);

  sample_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (SAMPLE_W)
  ) u_fifo (
    .clk     (MCU_CLK_25_000),
    .rst     (RESET),
    .push    (push),
    .wr_data (data_sync[SYNC_STAGES-1]),
    .pop     (DATA_ACK),
    .rd_data (SAMPLE_OUT),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (FIFO_LEVEL)
  );

  assign DATAREADY = ~fifo_empty;

  // Full implies non-empty, so an ack on a full FIFO always makes room
  assign drop = push & fifo_full & ~DATA_ACK;

  always_ff @(posedge MCU_CLK_25_000) begin
    if (RESET) begin
      OVERFLOW  <= 1'b0;
      OVF_COUNT <= '0;
    end else if (drop) begin
      OVERFLOW <= 1'b1;
      if (OVF_COUNT != '1) OVF_COUNT <= OVF_COUNT + OVF_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_gps_sample_capture.sv
// Bench for gps_sample_capture: directed phases followed by a randomized
// phase, all checked against a queue-based model of the sample buffer.
module tb_gps_sample_capture;

  localparam int DEPTH      = 8;
  localparam int SS         = 2;
  localparam int OW         = 8;
  localparam int LAT        = SS;      // edge k is written on edge k+SS
  localparam int RUN_STREAK = SS + 2;  // CAPTURE_EN samples needed to reach RUN
  localparam int OVF_MAX    = (1 << OW) - 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #20 clk = ~clk;

  logic                     RESET;
  logic                     CAPTURE_EN;
  logic                     GPS_CLK;
  logic                     GPS_I0, GPS_I1, GPS_Q0, GPS_Q1;
  logic [3:0]               SAMPLE_OUT;
  logic                     DATAREADY;
  logic                     DATA_ACK;
  logic [$clog2(DEPTH):0]   FIFO_LEVEL;
  logic                     OVERFLOW;
  logic [OW-1:0]            OVF_COUNT;

  gps_sample_capture #(
    .FIFO_DEPTH  (DEPTH),
    .SYNC_STAGES (SS),
    .OVF_CNT_W   (OW)
  ) dut (
    .MCU_CLK_25_000 (clk),
    .RESET          (RESET),
    .CAPTURE_EN     (CAPTURE_EN),
    .GPS_CLK        (GPS_CLK),
    .GPS_I0         (GPS_I0),
    .GPS_I1         (GPS_I1),
    .GPS_Q0         (GPS_Q0),
    .GPS_Q1         (GPS_Q1),
    .SAMPLE_OUT     (SAMPLE_OUT),
    .DATAREADY      (DATAREADY),
    .DATA_ACK       (DATA_ACK),
    .FIFO_LEVEL     (FIFO_LEVEL),
    .OVERFLOW       (OVERFLOW),
    .OVF_COUNT      (OVF_COUNT)
  );

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit mon_on = 1'b0;
  bit ack_rand = 1'b0;

  typedef struct {
    int         k;
    logic [3:0] nib;
  } cap_t;

  logic [3:0] exp_q[$];   // expected FIFO contents, head first
  cap_t       pend_q[$];  // GPS_CLK rises issued, not yet due
  int         lvl      = 0;
  int         ovf_cnt  = 0;
  bit         ovf_flag = 1'b0;
  int         streak   = 0;
  bit         run_prev;
  bit         pop_now;
  cap_t       cur;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Sample queue with fixed capacity, updated once per MCU clock edge.
  // A GPS rise first seen at edge k lands at edge k+LAT when capture was
  // running after edge k+LAT-1 (CAPTURE_EN seen high RUN_STREAK times).
  always @(posedge clk) begin
    cyc++;
    if (RESET) begin
      exp_q.delete();
      pend_q.delete();
      lvl      = 0;
      ovf_cnt  = 0;
      ovf_flag = 1'b0;
      streak   = 0;
    end else begin
      run_prev = (streak >= RUN_STREAK);
      pop_now  = DATA_ACK && (lvl > 0);
      while (pend_q.size() > 0 && pend_q[0].k + LAT < cyc) void'(pend_q.pop_front());
      if (pend_q.size() > 0 && pend_q[0].k + LAT == cyc) begin
        cur = pend_q.pop_front();
        if (run_prev) begin
          if (lvl == DEPTH && !pop_now) begin
            ovf_flag = 1'b1;
            if (ovf_cnt < OVF_MAX) ovf_cnt++;
          end else begin
            exp_q.push_back(cur.nib);
            lvl++;
          end
        end
      end
      if (pop_now) lvl--;
      if (CAPTURE_EN) begin
        if (streak < 1000) streak++;
      end else begin
        streak = 0;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (mon_on) begin
      check("fifo_level", 32'(FIFO_LEVEL), 32'(lvl));
      check("dataready",  32'(DATAREADY),  32'(lvl > 0));
      check("sample_out", 32'(SAMPLE_OUT), (lvl > 0 && exp_q.size() > 0) ? 32'(exp_q[0]) : 32'd0);
      check("overflow",   32'(OVERFLOW),   32'(ovf_flag));
      check("ovf_count",  32'(OVF_COUNT),  32'(ovf_cnt));
      // The bridge takes the head on the coming edge
      if (DATA_ACK && lvl > 0 && exp_q.size() > 0) void'(exp_q.pop_front());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #2;
    if (ack_rand) DATA_ACK = ($urandom_range(0, 1) == 1);
  endtask

  task automatic set_data(input logic [3:0] n);
    {GPS_I0, GPS_I1, GPS_Q0, GPS_Q1} = n;
  endtask

  // GPS_CLK high for 2 MCU clocks, then low for low_cycles clocks.
  // ack_at_push asserts DATA_ACK on the edge the sample is written.
  task automatic pulse(input logic [3:0] nib, input bit ack_at_push, input int low_cycles);
    cap_t c;
    set_data(nib);
    GPS_CLK = 1'b1;
    c.k   = cyc + 1;
    c.nib = nib;
    pend_q.push_back(c);
    tick();
    tick();
    GPS_CLK = 1'b0;
    set_data(4'($urandom_range(0, 15)));
    if (ack_at_push) DATA_ACK = 1'b1;
    tick();
    if (ack_at_push) DATA_ACK = 1'b0;
    repeat (low_cycles - 1) tick();
  endtask

  task automatic drain(input int n);
    DATA_ACK = 1'b1;
    repeat (n) tick();
    DATA_ACK = 1'b0;
    tick();
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    repeat (6) tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    RESET      = 1'b1;
    CAPTURE_EN = 1'b1;
    GPS_CLK    = 1'b1;
    DATA_ACK   = 1'b0;
    set_data(4'h0);
    @(posedge clk);
    #2;
    mon_on = 1'b1;
    tick();
    RESET = 1'b0;

    // GPS_CLK high through reset and after, capture enabled: nothing lands
    repeat (20) tick();
    GPS_CLK = 1'b0;
    repeat (4) tick();

    // Single edge, then a single ack
    pulse(4'b1011, 1'b0, 4);
    repeat (2) tick();
    drain(1);

    // Nine edges without acks: eight stored, one dropped; drain in order
    for (int i = 1; i <= 9; i++) pulse(4'(i), 1'b0, 3);
    repeat (3) tick();
    drain(DEPTH);

    // Full FIFO with an edge coinciding with an ack
    do_reset();
    repeat (DEPTH) pulse(4'($urandom_range(0, 15)), 1'b0, 3);
    pulse(4'($urandom_range(0, 15)), 1'b1, 3);
    repeat (2) tick();
    drain(DEPTH);

    // 300 edges without acks: drop counter saturates
    repeat (300) pulse(4'($urandom_range(0, 15)), 1'b0, 2);
    drain(DEPTH);

    // Reset with five buffered samples
    do_reset();
    repeat (5) pulse(4'($urandom_range(0, 15)), 1'b0, 3);
    do_reset();

    // Disarm with three buffered samples; later edges are ignored
    repeat (3) pulse(4'($urandom_range(0, 15)), 1'b0, 3);
    CAPTURE_EN = 1'b0;
    tick();
    repeat (3) pulse(4'($urandom_range(0, 15)), 1'b0, 3);
    drain(4);
    CAPTURE_EN = 1'b1;
    do_reset();

    // Randomized: random data, gaps, acks and occasional enable toggles
    ack_rand = 1'b1;
    repeat (250) begin
      if ($urandom_range(0, 15) == 0) CAPTURE_EN = ~CAPTURE_EN;
      pulse(4'($urandom_range(0, 15)), 1'b0, $urandom_range(2, 6));
    end
    ack_rand   = 1'b0;
    CAPTURE_EN = 1'b1;
    drain(DEPTH + 2);
    repeat (3) tick();

    mon_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard time limit
  initial begin
    #20000000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "time limit");
  end

endmodule
